// File: rtl/rv32i_hazard_ctrl_if.sv
// Control bundle between the rv32i pipeline and its hazard controller.
// master = pipeline side (reports stage contents), slave = hazard controller.
interface rv32i_hazard_ctrl_if;
   logic        idex_memread_i;
   logic [4:0]  idex_rd_addr_i;
   logic [4:0]  ifid_rs1_addr_i;
   logic [4:0]  ifid_rs2_addr_i;
   logic        ex_branch_taken_i;
   logic        ex_div_start_i;
   logic        dmem_req_i;
   logic        dmem_ack_i;
   logic        stall_if_w;
   logic        stall_id_w;
   logic        stall_ex_w;
   logic        stall_mem_w;
   logic        flush_if_w;
   logic        flush_id_w;
   logic        flush_ex_w;
   logic        flush_mem_w;
   logic        div_busy_o;
   logic        div_done_o;
   logic [31:0] stall_cycles_o;

   modport master (
      output idex_memread_i, idex_rd_addr_i, ifid_rs1_addr_i, ifid_rs2_addr_i,
             ex_branch_taken_i, ex_div_start_i, dmem_req_i, dmem_ack_i,
      input  stall_if_w, stall_id_w, stall_ex_w, stall_mem_w,
             flush_if_w, flush_id_w, flush_ex_w, flush_mem_w,
             div_busy_o, div_done_o, stall_cycles_o
   );

   modport slave (
      input  idex_memread_i, idex_rd_addr_i, ifid_rs1_addr_i, ifid_rs2_addr_i,
             ex_branch_taken_i, ex_div_start_i, dmem_req_i, dmem_ack_i,
      output stall_if_w, stall_id_w, stall_ex_w, stall_mem_w,
             flush_if_w, flush_id_w, flush_ex_w, flush_mem_w,
             div_busy_o, div_done_o, stall_cycles_o
   );
endinterface

// File: rtl/rv32i_hazard_ctrl.sv
// Hazard controller for the 5-stage rv32i core: load-use bubbles, taken-branch
// flushes, multi-cycle divide occupancy of EX and data-memory wait states.
module rv32i_hazard_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   rv32i_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {RUN, DIV_WAIT, MEM_WAIT} state_t;

   // The start cycle itself is the first EX cycle, so the wait counts DIV_CYCLES-2 down to 0.
   localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_CYCLES > 1) ? CNT_W'(DIV_CYCLES - 2) : '0;

   state_t           state_reg, state_next;
   state_t           prior_reg, prior_next;
   state_t           eff_state;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      stall_cnt_reg;
   logic [3:0]       stall_v;   // {if, id, ex, mem}
   logic [3:0]       flush_v;   // {if, id, ex, mem}
   logic             done_v;
   logic             memwait;
   logic             load_use;
   logic [1:0]       rs_hit;
   logic [4:0]       rs_addr [2];

   assign memwait   = hz.dmem_req_i & ~hz.dmem_ack_i;
   assign rs_addr[0] = hz.ifid_rs1_addr_i;
   assign rs_addr[1] = hz.ifid_rs2_addr_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rs_hit
         assign rs_hit[gi] = (hz.idex_rd_addr_i == rs_addr[gi]);
      end
   endgenerate

   assign load_use = hz.idex_memread_i & (hz.idex_rd_addr_i != 5'd0) & (|rs_hit);

   always_comb begin
      stall_v    = 4'b0000;
      flush_v    = 4'b0000;
      done_v     = 1'b0;
      state_next = state_reg;
      prior_next = prior_reg;
      cnt_next   = (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : cnt_reg;
      // MEM_WAIT is transparent once memwait drops: the saved state decides that cycle.
      eff_state  = (state_reg == MEM_WAIT) ? prior_reg : state_reg;

      if (memwait) begin
         stall_v    = 4'b1111;
         state_next = MEM_WAIT;
         prior_next = eff_state;
      end else begin
         case (eff_state)
            RUN: begin
               state_next = RUN;
               if (hz.ex_branch_taken_i) begin
                  flush_v = 4'b1100;
               end else if (hz.ex_div_start_i) begin
                  if (DIV_CYCLES > 1) begin
                     stall_v    = 4'b1110;
                     flush_v    = 4'b0001;
                     cnt_next   = DIV_LOAD;
                     state_next = DIV_WAIT;
                  end else begin
                     done_v = 1'b1;
                  end
               end else if (load_use) begin
                  stall_v = 4'b1100;
                  flush_v = 4'b0010;
               end
            end
            DIV_WAIT: begin
               if (cnt_reg != '0) begin
                  stall_v    = 4'b1110;
                  flush_v    = 4'b0001;
                  state_next = DIV_WAIT;
               end else begin
                  done_v     = 1'b1;
                  state_next = RUN;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= RUN;
         prior_reg     <= RUN;
         cnt_reg       <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         prior_reg <= prior_next;
         cnt_reg   <= cnt_next;
         if (stall_v[3]) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
      end
   end

   assign hz.stall_if_w     = ~rst_i & stall_v[3];
   assign hz.stall_id_w     = ~rst_i & stall_v[2];
   assign hz.stall_ex_w     = ~rst_i & stall_v[1];
   assign hz.stall_mem_w    = ~rst_i & stall_v[0];
   assign hz.flush_if_w     = ~rst_i & flush_v[3];
   assign hz.flush_id_w     = ~rst_i & flush_v[2];
   assign hz.flush_ex_w     = ~rst_i & flush_v[1];
   assign hz.flush_mem_w    = ~rst_i & flush_v[0];
   assign hz.div_done_o     = ~rst_i & done_v;
   assign hz.div_busy_o     = ~rst_i & ((state_reg == DIV_WAIT) |
                                        ((state_reg == MEM_WAIT) & (prior_reg == DIV_WAIT)));
   assign hz.stall_cycles_o = rst_i ? 32'd0 : stall_cnt_reg;
endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Directed bench for rv32i_hazard_ctrl: a DIV_CYCLES=4 instance for the main
// scenarios plus a DIV_CYCLES=1 instance for the single-cycle divide case.
module tb_rv32i_hazard_ctrl;
   logic clk;
   logic rst;
   int   check_count;
   int   pass_count;

   rv32i_hazard_ctrl_if hif();
   rv32i_hazard_ctrl_if hif1();

   rv32i_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(6)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .hz    (hif)
   );

   rv32i_hazard_ctrl #(.DIV_CYCLES(1), .CNT_W(6)) u_dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .hz    (hif1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] stl, flu, stl1;
   assign stl  = {hif.stall_if_w, hif.stall_id_w, hif.stall_ex_w, hif.stall_mem_w};
   assign flu  = {hif.flush_if_w, hif.flush_id_w, hif.flush_ex_w, hif.flush_mem_w};
   assign stl1 = {hif1.stall_if_w, hif1.stall_id_w, hif1.stall_ex_w, hif1.stall_mem_w};

   always @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0({hif.ex_branch_taken_i, hif.ex_div_start_i, hif.idex_memread_i}))
            else $error("branch/div/load issued together in EX");
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got === exp) begin
         pass_count++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic br, input logic dv,
                        input logic req, input logic ack);
      hif.idex_memread_i    = mr;
      hif.idex_rd_addr_i    = rd;
      hif.ifid_rs1_addr_i   = rs1;
      hif.ifid_rs2_addr_i   = rs2;
      hif.ex_branch_taken_i = br;
      hif.ex_div_start_i    = dv;
      hif.dmem_req_i        = req;
      hif.dmem_ack_i        = ack;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ctl(input string tag, input logic [3:0] s, input logic [3:0] f,
                             input logic done, input logic busy);
      $display("txn %-12s stall=%b flush=%b done=%b busy=%b cycles=%0d",
               tag, stl, flu, hif.div_done_o, hif.div_busy_o, hif.stall_cycles_o);
      check({tag, ".stall"}, 32'(stl), 32'(s));
      check({tag, ".flush"}, 32'(flu), 32'(f));
      check({tag, ".done"},  32'(hif.div_done_o), 32'(done));
      check({tag, ".busy"},  32'(hif.div_busy_o), 32'(busy));
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      rst = 1'b1;
      hif1.idex_memread_i = 1'b0;  hif1.idex_rd_addr_i = 5'd0;
      hif1.ifid_rs1_addr_i = 5'd0; hif1.ifid_rs2_addr_i = 5'd0;
      hif1.ex_branch_taken_i = 1'b0; hif1.ex_div_start_i = 1'b0;
      hif1.dmem_req_i = 1'b0; hif1.dmem_ack_i = 1'b0;

      // Reset: everything quiet even with a load-use pattern on the inputs.
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick(); tick();
      check("reset.cycles", hif.stall_cycles_o, 32'd0);
      rst = 1'b0;

      // Load-use on rs1, bubble, rd=0, rs2 match, no match.
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("lu_rs1", 4'b1100, 4'b0010, 1'b0, 1'b0);
      tick();
      drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("lu_bubble", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("lu.cycles1", hif.stall_cycles_o, 32'd1);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("lu_rd0", 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("lu_rs2", 4'b1100, 4'b0010, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("lu_nomatch", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("lu.cycles2", hif.stall_cycles_o, 32'd2);
      tick();

      // Taken branch pulse.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_ctl("branch", 4'b0000, 4'b1100, 1'b0, 1'b0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("branch_off", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("branch.cycles", hif.stall_cycles_o, 32'd2);
      tick();

      // Divide, DIV_CYCLES=4: stall cycles 0-2, done in cycle 3.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ctl("div_c0", 4'b1110, 4'b0001, 1'b0, 1'b0);
      tick();
      expect_ctl("div_c1", 4'b1110, 4'b0001, 1'b0, 1'b1);
      tick();
      expect_ctl("div_c2", 4'b1110, 4'b0001, 1'b0, 1'b1);
      tick();
      expect_ctl("div_c3", 4'b0000, 4'b0000, 1'b1, 1'b1);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("div_c4", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("div.cycles", hif.stall_cycles_o, 32'd5);
      tick();

      // Memwait for 3 cycles with branch held, then branch flush on the ack cycle.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
         expect_ctl($sformatf("mw_c%0d", i), 4'b1111, 4'b0000, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      expect_ctl("mw_ack", 4'b0000, 4'b1100, 1'b0, 1'b0);
      check("mw.cycles", hif.stall_cycles_o, 32'd8);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("mw_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();

      // Divide with memwait in cycles 2-5: done once in cycle 6.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ctl("dmw_c0", 4'b1110, 4'b0001, 1'b0, 1'b0);
      tick();
      expect_ctl("dmw_c1", 4'b1110, 4'b0001, 1'b0, 1'b1);
      tick();
      for (int i = 2; i <= 5; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
         expect_ctl($sformatf("dmw_c%0d", i), 4'b1111, 4'b0000, 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ctl("dmw_c6", 4'b0000, 4'b0000, 1'b1, 1'b1);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("dmw_c7", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("dmw.cycles", hif.stall_cycles_o, 32'd14);
      tick();

      // Reset in cycle 2 of a divide, then a fresh full-length divide.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ctl("rdiv_c0", 4'b1110, 4'b0001, 1'b0, 1'b0);
      tick();
      expect_ctl("rdiv_c1", 4'b1110, 4'b0001, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      #1;
      expect_ctl("rdiv_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("rdiv.rst_cycles", hif.stall_cycles_o, 32'd0);
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ctl("rdiv_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("rdiv.cycles0", hif.stall_cycles_o, 32'd0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_ctl("ndiv_c0", 4'b1110, 4'b0001, 1'b0, 1'b0);
      tick();
      expect_ctl("ndiv_c1", 4'b1110, 4'b0001, 1'b0, 1'b1);
      tick();
      expect_ctl("ndiv_c2", 4'b1110, 4'b0001, 1'b0, 1'b1);
      tick();
      expect_ctl("ndiv_c3", 4'b0000, 4'b0000, 1'b1, 1'b1);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ndiv.cycles", hif.stall_cycles_o, 32'd3);
      tick();

      // Single-cycle divide: done in the start cycle, no stall.
      hif1.ex_div_start_i = 1'b1;
      #1;
      $display("txn div1         stall=%b done=%b busy=%b", stl1, hif1.div_done_o, hif1.div_busy_o);
      check("div1.done",  32'(hif1.div_done_o), 32'd1);
      check("div1.stall", 32'(stl1), 32'd0);
      tick();
      hif1.ex_div_start_i = 1'b0;
      #1;
      check("div1.busy",   32'(hif1.div_busy_o), 32'd0);
      check("div1.cycles", hif1.stall_cycles_o, 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
